// File: rtl/dht11_pkg.sv
// dht11_pkg: shared FSM states, status codes and sizes for the DHT11 frame transmitter
package dht11_pkg;
    localparam int FRAME_LEN = 6;
    localparam int CNT_W = 26;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_KICK  = 3'd1;
    localparam state_t S_ARM   = 3'd2;
    localparam state_t S_MEAS  = 3'd3;
    localparam state_t S_LATCH = 3'd4;
    localparam state_t S_SEND  = 3'd5;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_CRC     = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_EMPTY   = 8'h03;
endpackage

// File: rtl/dht11_frame_tx_byte_serializer.sv
// dht11_frame_tx_byte_serializer: streams a latched frame byte by byte over valid/ready
module dht11_frame_tx_byte_serializer
    import dht11_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [8*FRAME_LEN-1:0] frame,
    input  logic                   ready,
    output logic [7:0]             data,
    output logic                   valid,
    output logic [2:0]             index,
    output logic                   done
);
    logic [8*FRAME_LEN-1:0] frame_q;
    logic xfer;
    logic last;
    assign xfer = valid & ready;
    assign last = index == 3'(FRAME_LEN - 1);
    assign data = valid ? frame_q[{index, 3'b000} +: 8] : 8'h00;
    // Frame capture, index advance on each transfer, done pulse after the final byte
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            valid   <= 1'b0;
            index   <= '0;
            done    <= 1'b0;
        end else begin
            done <= xfer & last;
            if (load) begin
                frame_q <= frame;
                valid   <= 1'b1;
                index   <= '0;
            end else if (xfer) begin
                valid <= !last;
                index <= last ? 3'd0 : index + 3'd1;
            end
        end
    end
endmodule

// File: rtl/dht11_frame_tx.sv
// dht11_frame_tx: drives a DHT11 reader measurement and sends a 6-byte status+data frame
module dht11_frame_tx
    import dht11_pkg::*;
#(
    parameter int ARM_TIMEOUT  = 1000,
    parameter int MEAS_TIMEOUT = 10_000_000
)(
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SENS_WAIT,
    input  logic [7:0] HUM_INT,
    input  logic [7:0] HUM_FLOAT,
    input  logic [7:0] TEMP_INT,
    input  logic [7:0] TEMP_FLOAT,
    input  logic [7:0] CRC,
    output logic       SENS_EN,
    output logic       SENS_RST,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] STATUS
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             tmo;
    logic [7:0]       sum;
    logic [7:0]       status_next;
    logic [2:0]       index;
    assign cnt_inc = cnt + 1'b1;
    assign sum = HUM_INT + HUM_FLOAT + TEMP_INT + TEMP_FLOAT;
    assign status_next = tmo ? ST_TIMEOUT
                       : ({HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC} == 40'd0) ? ST_EMPTY
                       : (sum != CRC) ? ST_CRC : ST_OK;
    assign SENS_EN  = state inside {S_KICK, S_ARM, S_MEAS, S_LATCH};
    assign SENS_RST = state == S_KICK;
    assign BUSY     = state != S_IDLE;
    // Measurement sequencing; a wait edge on the timeout cycle wins over the timeout
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            tmo    <= 1'b0;
            STATUS <= ST_OK;
        end else begin
            case (state)
                S_IDLE: if (START) state <= S_KICK;
                S_KICK: begin
                    cnt   <= '0;
                    tmo   <= 1'b0;
                    state <= S_ARM;
                end
                S_ARM: begin
                    if (SENS_WAIT) begin
                        cnt   <= '0;
                        state <= S_MEAS;
                    end else if (cnt_inc == CNT_W'(ARM_TIMEOUT)) begin
                        tmo   <= 1'b1;
                        state <= S_LATCH;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_MEAS: begin
                    if (!SENS_WAIT) begin
                        state <= S_LATCH;
                    end else if (cnt_inc == CNT_W'(MEAS_TIMEOUT)) begin
                        tmo   <= 1'b1;
                        state <= S_LATCH;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_LATCH: begin
                    STATUS <= status_next;
                    state  <= S_SEND;
                end
                S_SEND: if (TX_VALID && TX_READY && index == 3'(FRAME_LEN - 1)) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
    dht11_frame_tx_byte_serializer u_ser (
        .clk   (CLK),
        .rst   (RST),
        .load  (state == S_LATCH),
        .frame ({CRC, TEMP_FLOAT, TEMP_INT, HUM_FLOAT, HUM_INT, status_next}),
        .ready (TX_READY),
        .data  (TX_DATA),
        .valid (TX_VALID),
        .index (index),
        .done  (DONE)
    );
endmodule

// File: tb/tb_dht11_frame_tx.sv
// tb_dht11_frame_tx: scoreboard bench with a reader model and a TX byte monitor
module tb_dht11_frame_tx;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       SENS_WAIT = 1'b0;
    logic       TX_READY = 1'b1;
    logic [7:0] HUM_INT = 8'h00;
    logic [7:0] HUM_FLOAT = 8'h00;
    logic [7:0] TEMP_INT = 8'h00;
    logic [7:0] TEMP_FLOAT = 8'h00;
    logic [7:0] CRC = 8'h00;
    logic       SENS_EN;
    logic       SENS_RST;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       BUSY;
    logic       DONE;
    logic [7:0] STATUS;

    int         tests = 0;
    int         fails = 0;
    int         xfers = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         xfer_cyc[$];
    bit         bp = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    dht11_frame_tx dut (
        .CLK(CLK), .RST(RST), .START(START), .SENS_WAIT(SENS_WAIT),
        .HUM_INT(HUM_INT), .HUM_FLOAT(HUM_FLOAT), .TEMP_INT(TEMP_INT),
        .TEMP_FLOAT(TEMP_FLOAT), .CRC(CRC), .SENS_EN(SENS_EN), .SENS_RST(SENS_RST),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY), .DONE(DONE), .STATUS(STATUS)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Cycle counter
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Sink readiness: always ready, or about 30% duty under backpressure
    initial forever begin
        @(posedge CLK);
        #1;
        TX_READY = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability and DONE
    initial forever begin
        @(negedge CLK);
        if (stall_prev) begin
            check("stall_valid_held", TX_VALID, 1);
            check("stall_data_stable", TX_DATA, stall_data);
        end
        stall_prev = TX_VALID && !TX_READY && !RST;
        stall_data = TX_DATA;
        if (TX_VALID && TX_READY && !RST) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no transfer (cycle %0d)", TX_DATA, cyc);
            end else begin
                check("tx_byte", TX_DATA, exp_q.pop_front());
            end
            xfers++;
            xfer_cyc.push_back(cyc);
        end
        if (DONE) begin
            done_cnt++;
            check("busy_low_at_done", BUSY, 0);
        end
    end

    task automatic start_meas();
        @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        check("start_to_sens_rst", SENS_RST, 1);
        check("start_to_busy", BUSY, 1);
    endtask

    task automatic reader(input int hold);
        int n;
        n = 0;
        while (!(SENS_EN && !SENS_RST) && n < 10) begin
            @(posedge CLK);
            #1 n++;
        end
        check("arm_entered", SENS_EN && !SENS_RST, 1);
        repeat (3) @(posedge CLK);
        #1 SENS_WAIT = 1'b1;
        repeat (hold) @(posedge CLK);
        #1 SENS_WAIT = 1'b0;
        @(posedge CLK);
        #1;
        check("latch_no_valid", TX_VALID, 0);
        check("latch_sens_en", SENS_EN, 1);
        @(posedge CLK);
        #1;
        check("wait_fall_to_valid", TX_VALID, 1);
        check("send_sens_en_low", SENS_EN, 0);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge CLK);
            n++;
        end
        #1;
        check("done_seen", done_cnt != d0, 1);
    endtask

    task automatic run_frame(input logic [7:0] hi, input logic [7:0] hf, input logic [7:0] ti,
                             input logic [7:0] tf, input logic [7:0] crc, input int hold,
                             input logic [7:0] st, input bit mid_start, input bit chk_b2b);
        int d0;
        int x0;
        int n;
        HUM_INT = hi;
        HUM_FLOAT = hf;
        TEMP_INT = ti;
        TEMP_FLOAT = tf;
        CRC = crc;
        exp_q.push_back(st);
        exp_q.push_back(hi);
        exp_q.push_back(hf);
        exp_q.push_back(ti);
        exp_q.push_back(tf);
        exp_q.push_back(crc);
        xfer_cyc.delete();
        d0 = done_cnt;
        x0 = xfers;
        start_meas();
        if (hold > 0) begin
            reader(hold);
        end else begin
            n = 0;
            while (!TX_VALID && n < 3000) begin
                @(posedge CLK);
                #1 n++;
            end
            check("arm_timeout_cycles", n, 1002);
        end
        if (mid_start) begin
            @(posedge CLK);
            #1 START = 1'b1;
            @(posedge CLK);
            #1 START = 1'b0;
        end
        wait_done(d0);
        check("frame_len", xfers - x0, 6);
        check("scoreboard_empty", exp_q.size(), 0);
        check("status", STATUS, st);
        check("sens_en_after", SENS_EN, 0);
        if (chk_b2b) check("back_to_back", (xfer_cyc.size() == 6) ? xfer_cyc[5] - xfer_cyc[0] : -1, 5);
        repeat (20) @(posedge CLK);
        #1;
        check("single_done", done_cnt - d0, 1);
        check("idle_not_busy", BUSY, 0);
    endtask

    // Watchdog
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed sequence
    initial begin
        int n;
        int x0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_sens_en", SENS_EN, 0);
        check("rst_sens_rst", SENS_RST, 0);
        check("rst_tx_valid", TX_VALID, 0);
        check("rst_tx_data", TX_DATA, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_status", STATUS, 0);
        RST = 1'b0;
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 100, 8'h00, 1'b0, 1'b1);
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h51, 100, 8'h01, 1'b0, 1'b0);
        run_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 0, 8'h02, 1'b0, 1'b0);
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 50, 8'h03, 1'b0, 1'b0);
        run_frame(8'hF0, 8'h20, 8'h10, 8'h05, 8'h25, 40, 8'h00, 1'b0, 1'b1);
        bp = 1'b1;
        run_frame(8'h40, 8'h05, 8'h1A, 8'h03, 8'h62, 30, 8'h00, 1'b1, 1'b0);
        bp = 1'b0;
        repeat (3) @(posedge CLK);
        HUM_INT = 8'h12;
        HUM_FLOAT = 8'h34;
        TEMP_INT = 8'h56;
        TEMP_FLOAT = 8'h78;
        CRC = 8'h14;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h14);
        x0 = xfers;
        start_meas();
        reader(20);
        n = 0;
        while (xfers - x0 < 2 && n < 50) begin
            @(posedge CLK);
            #1 n++;
        end
        check("bytes_before_reset", xfers - x0, 2);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_tx_valid", TX_VALID, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_sens_en", SENS_EN, 0);
        check("midrst_status", STATUS, 0);
        RST = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge CLK);
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 60, 8'h00, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
